// File: rtl/vec_pkg.sv
// Shared types and widths for the row/column pair streamer and its MAC.
// ACC_W is the accumulator width the downstream MAC needs for N products of W-bit operands.
package vec_pkg;

    localparam int DEF_N = 4;
    localparam int DEF_W = 11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    function automatic int acc_width(input int w, input int n);
        return 2 * w + $clog2(n);
    endfunction

    localparam int ACC_W = acc_width(DEF_W, DEF_N);

endpackage

// File: rtl/vec_buf.sv
// N x W element buffer: one synchronous write port, one combinational read port.
// Out-of-range addresses are dropped on write and read back as zero.
module vec_buf
    import vec_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int W  = DEF_W,
    parameter int AW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [W-1:0]  i_wr_data,
    input  logic [AW-1:0] i_rd_addr,
    output logic [W-1:0]  o_rd_data
);

    logic [W-1:0] r_mem [N];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < N; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wr_en && (int'(i_wr_addr) < N)) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = (int'(i_rd_addr) < N) ? r_mem[i_rd_addr] : '0;

endmodule

// File: rtl/vec_pair_streamer.sv
// Streams (row[i], col[i]) pairs with first/last framing to the downstream MAC.
// Buffers load only while idle, so a running stream always sees a frozen snapshot.
//
//   state     | meaning
//   ----------+--------------------------------------------------------
//   ST_IDLE   | buffers writable, waiting for start
//   ST_STREAM | presenting pair r_idx, advancing on each accepted beat
//   ST_DONE   | one-cycle done pulse, then back to idle
module vec_pair_streamer
    import vec_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int W  = DEF_W,
    parameter int AW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          CLOCK_50,
    input  logic          reset,
    input  logic          wr_en,
    input  logic          wr_sel,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [W-1:0]  k,
    output logic [W-1:0]  l,
    output logic          pair_valid,
    input  logic          pair_ready,
    output logic          first,
    output logic          last
);

    localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

    state_t          r_state;
    logic [AW-1:0]   r_idx;
    logic            r_busy;
    logic            r_done;
    logic            r_pair_valid;
    logic            r_first;
    logic            r_last;
    logic [W-1:0]    r_k;
    logic [W-1:0]    r_l;

    logic            w_row_we;
    logic            w_col_we;
    logic            w_accept;
    logic [AW-1:0]   w_rd_idx;
    logic [W-1:0]    w_row_data;
    logic [W-1:0]    w_col_data;

    assign w_row_we = wr_en && !wr_sel && (r_state == ST_IDLE);
    assign w_col_we = wr_en &&  wr_sel && (r_state == ST_IDLE);
    assign w_accept = r_pair_valid && pair_ready;
    // Read one element ahead so the next pair is ready on the accepting edge.
    assign w_rd_idx = r_pair_valid ? AW'(r_idx + 1'b1) : '0;

    vec_buf #(.N(N), .W(W), .AW(AW)) u_row_buf (
        .i_clk     (CLOCK_50),
        .i_rst     (reset),
        .i_wr_en   (w_row_we),
        .i_wr_addr (wr_addr),
        .i_wr_data (wr_data),
        .i_rd_addr (w_rd_idx),
        .o_rd_data (w_row_data)
    );

    vec_buf #(.N(N), .W(W), .AW(AW)) u_col_buf (
        .i_clk     (CLOCK_50),
        .i_rst     (reset),
        .i_wr_en   (w_col_we),
        .i_wr_addr (wr_addr),
        .i_wr_data (wr_data),
        .i_rd_addr (w_rd_idx),
        .o_rd_data (w_col_data)
    );

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pair_valid <= 1'b0;
            r_first      <= 1'b0;
            r_last       <= 1'b0;
            r_k          <= '0;
            r_l          <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state <= ST_STREAM;
                        r_busy  <= 1'b1;
                        r_idx   <= '0;
                    end
                end
                ST_STREAM: begin
                    if (!r_pair_valid || w_accept) begin
                        if (r_pair_valid && (r_idx == LAST_IDX)) begin
                            r_state      <= ST_DONE;
                            r_pair_valid <= 1'b0;
                            r_first      <= 1'b0;
                            r_last       <= 1'b0;
                            r_done       <= 1'b1;
                        end else begin
                            r_idx        <= w_rd_idx;
                            r_k          <= w_row_data;
                            r_l          <= w_col_data;
                            r_first      <= (w_rd_idx == '0);
                            r_last       <= (w_rd_idx == LAST_IDX);
                            r_pair_valid <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_idx   <= '0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign k          = r_k;
    assign l          = r_l;
    assign pair_valid = r_pair_valid;
    assign first      = r_first;
    assign last       = r_last;

endmodule

// File: tb/tb_vec_pair_streamer.sv
// Scoreboard bench for vec_pair_streamer: stimulus queues expected pairs and dot products,
// a negedge monitor pops them on every accepted beat and on every done pulse.
module tb_vec_pair_streamer;
    import vec_pkg::*;

    localparam int N  = 4;
    localparam int W  = 11;
    localparam int AW = 2;

    typedef struct packed {
        logic [W-1:0] k;
        logic [W-1:0] l;
        logic         f;
        logic         la;
    } pair_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset = 1'b1;
    logic          wr_en = 1'b0;
    logic          wr_sel = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [W-1:0]  wr_data = '0;
    logic          start = 1'b0;
    logic          pair_ready = 1'b1;
    logic          busy, done, pair_valid, first, last;
    logic [W-1:0]  k, l;

    logic          n1_wr_en = 1'b0;
    logic          n1_wr_sel = 1'b0;
    logic [0:0]    n1_wr_addr = '0;
    logic [W-1:0]  n1_wr_data = '0;
    logic          n1_start = 1'b0;
    logic          n1_ready = 1'b1;
    logic          n1_busy, n1_done, n1_pv, n1_first, n1_last;
    logic [W-1:0]  n1_k, n1_l;

    vec_pair_streamer #(.N(N), .W(W), .AW(AW)) u_dut (
        .CLOCK_50   (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_sel     (wr_sel),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .k          (k),
        .l          (l),
        .pair_valid (pair_valid),
        .pair_ready (pair_ready),
        .first      (first),
        .last       (last)
    );

    vec_pair_streamer #(.N(1), .W(W), .AW(1)) u_dut_n1 (
        .CLOCK_50   (clk),
        .reset      (reset),
        .wr_en      (n1_wr_en),
        .wr_sel     (n1_wr_sel),
        .wr_addr    (n1_wr_addr),
        .wr_data    (n1_wr_data),
        .start      (n1_start),
        .busy       (n1_busy),
        .done       (n1_done),
        .k          (n1_k),
        .l          (n1_l),
        .pair_valid (n1_pv),
        .pair_ready (n1_ready),
        .first      (n1_first),
        .last       (n1_last)
    );

    pair_t            exp_q[$];
    logic [ACC_W-1:0] sum_q[$];
    int               checks = 0;
    int               errors = 0;
    int               done_cnt = 0;
    logic [ACC_W-1:0] mac_sum = '0;
    logic             prev_stall = 1'b0;
    pair_t            prev_pair = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: compare every accepted pair, hold-stability under stall, and MAC result at done.
    always @(negedge clk) begin
        pair_t e;
        if (!reset) begin
            if (pair_valid && prev_stall)
                chk("hold_stable", {k, l, first, last}, prev_pair);
            if (pair_valid && pair_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pair_unexpected: got (%0d,%0d) expected none", k, l);
                end else begin
                    e = exp_q.pop_front();
                    chk("pair_k", k, e.k);
                    chk("pair_l", l, e.l);
                    chk("pair_first", first, e.f);
                    chk("pair_last", last, e.la);
                end
                mac_sum = first ? (ACC_W'(k) * ACC_W'(l)) : (mac_sum + ACC_W'(k) * ACC_W'(l));
            end
            if (done) begin
                done_cnt++;
                if (sum_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL done_unexpected: got done expected none");
                end else begin
                    chk("mac_sum", mac_sum, sum_q.pop_front());
                end
                chk("pairs_left_at_done", exp_q.size(), 0);
            end
        end
        prev_stall = pair_valid && !pair_ready;
        prev_pair  = {k, l, first, last};
    end

    task automatic wr(input logic sel, input logic [AW-1:0] a, input logic [W-1:0] d);
        @(posedge clk); #1;
        wr_en = 1'b1; wr_sel = sel; wr_addr = a; wr_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic load(input logic [W-1:0] r0, r1, r2, r3, c0, c1, c2, c3);
        wr(1'b0, 2'd0, r0); wr(1'b0, 2'd1, r1); wr(1'b0, 2'd2, r2); wr(1'b0, 2'd3, r3);
        wr(1'b1, 2'd0, c0); wr(1'b1, 2'd1, c1); wr(1'b1, 2'd2, c2); wr(1'b1, 2'd3, c3);
    endtask

    task automatic expect_stream(input logic [W-1:0] r0, r1, r2, r3, c0, c1, c2, c3,
                                 input logic [ACC_W-1:0] sum);
        exp_q.push_back({r0, c0, 1'b1, 1'b0});
        exp_q.push_back({r1, c1, 1'b0, 1'b0});
        exp_q.push_back({r2, c2, 1'b0, 1'b0});
        exp_q.push_back({r3, c3, 1'b0, 1'b1});
        sum_q.push_back(sum);
    endtask

    // Cycle 1 is the one after start is sampled; stall/inject refer to those cycle numbers.
    task automatic run(input string name, input int exp_cyc, input int stall_from,
                       input int stall_len, input int inject_cyc);
        int cyc;
        @(posedge clk); #1;
        start = 1'b1; pair_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (1) begin
            @(negedge clk);
            if (done) break;
            if (cyc >= exp_cyc + 8) begin
                checks++;
                errors++;
                $display("FAIL %s_timeout: got no done after %0d cycles expected %0d", name, cyc, exp_cyc);
                break;
            end
            @(posedge clk); #1;
            cyc++;
            pair_ready = !(cyc >= stall_from && cyc < stall_from + stall_len);
            start   = (cyc == inject_cyc);
            wr_en   = (cyc == inject_cyc);
            wr_sel  = 1'b0;
            wr_addr = '0;
            wr_data = 11'd99;
        end
        chk({name, "_cycles"}, cyc, exp_cyc);
        @(posedge clk); #1;
        start = 1'b0; wr_en = 1'b0; pair_ready = 1'b1;
        @(negedge clk);
        chk({name, "_busy_after_done"}, busy, 0);
        chk({name, "_done_one_cycle"}, done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", pair_valid, 0);
        chk("rst_first_last", {first, last}, 0);
        chk("rst_kl", {k, l}, 0);

        load(1, 2, 3, 4, 5, 6, 7, 8);
        expect_stream(1, 2, 3, 4, 5, 6, 7, 8, 70);
        run("basic", 6, 0, 0, 0);

        load(2047, 2047, 2047, 2047, 2047, 2047, 2047, 2047);
        expect_stream(2047, 2047, 2047, 2047, 2047, 2047, 2047, 2047, 24'd16760836);
        run("maxval", 6, 0, 0, 0);

        load(1, 2, 3, 4, 5, 6, 7, 8);
        expect_stream(1, 2, 3, 4, 5, 6, 7, 8, 70);
        run("backpressure", 9, 3, 3, 0);

        d0 = done_cnt;
        expect_stream(1, 2, 3, 4, 5, 6, 7, 8, 70);
        run("ignored_req", 6, 0, 0, 3);
        repeat (4) @(negedge clk);
        chk("ignored_no_restart", busy, 0);
        chk("ignored_done_once", done_cnt - d0, 1);
        expect_stream(1, 2, 3, 4, 5, 6, 7, 8, 70);
        run("after_ignored", 6, 0, 0, 0);

        expect_stream(1, 2, 3, 4, 5, 6, 7, 8, 70);
        d0 = done_cnt;
        @(posedge clk); #1 start = 1'b1; pair_ready = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("midrst_pair2_shown", k, 3);
        @(posedge clk); #1 reset = 1'b0;
        exp_q.delete();
        sum_q.delete();
        @(negedge clk);
        chk("midrst_valid", pair_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        repeat (4) @(negedge clk);
        chk("midrst_no_done", done_cnt - d0, 0);
        expect_stream(0, 0, 0, 0, 0, 0, 0, 0, 0);
        run("after_reset", 6, 0, 0, 0);

        @(posedge clk); #1 n1_wr_en = 1'b1; n1_wr_sel = 1'b0; n1_wr_addr = 1'b0; n1_wr_data = 11'd7;
        @(posedge clk); #1 n1_wr_sel = 1'b1; n1_wr_data = 11'd9;
        @(posedge clk); #1 n1_wr_sel = 1'b0; n1_wr_addr = 1'b1; n1_wr_data = 11'd55;
        @(posedge clk); #1 n1_wr_sel = 1'b1; n1_wr_data = 11'd66;
        @(posedge clk); #1 n1_wr_en = 1'b0; n1_start = 1'b1;
        @(posedge clk); #1 n1_start = 1'b0;
        @(negedge clk);
        chk("n1_busy_no_pair", {n1_busy, n1_pv}, 2'b10);
        @(negedge clk);
        chk("n1_valid", n1_pv, 1);
        chk("n1_pair", {n1_k, n1_l}, {11'd7, 11'd9});
        chk("n1_first_last", {n1_first, n1_last}, 2'b11);
        @(negedge clk);
        chk("n1_done", {n1_done, n1_pv}, 2'b10);
        @(negedge clk);
        chk("n1_idle", {n1_done, n1_busy}, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
